ds_bypass_stage: RTL and testbench
==================================

# ds_bypass_stage

Parametrised decode-stage pipeline slot with a generalised operand bypass network. It holds the IF→ID payload under the valid/allowin handshake. It resolves each source operand against NUM_FWD downstream forwarding ports. Priority is nearest stage first. The slot stalls only when the winning producer's data is not yet available, and it adds a synchronous flush and a saturating stall-cycle counter. It sits between the fetch stage and the execute stage; the instruction decoder stays outside and feeds register addresses back in.

## Interface
- DW, 32, operand/data width
- RF_AW, 5, register address width; register 0 reads as zero and is never forwarded
- NUM_FWD, 3, number of forwarding sources; index 0 = nearest stage (execute)
- PAYLOAD_W, 64, width of fetch payload ({inst, pc} by default)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fs_to_ds_valid  in  1  fetch payload valid
- fs_to_ds_bus  in  PAYLOAD_W  fetch payload
- ds_allowin  out  1  slot can accept a payload this cycle
- es_allowin  in  1  execute stage can accept
- ds_to_es_valid  out  1  slot holds a valid, non-stalled, non-flushed instruction
- flush  in  1  discard held instruction (branch mispredict / exception)
- ds_valid  out  1  registered slot occupancy
- ds_payload  out  PAYLOAD_W  registered payload, to external decoder
- rs_addr, rt_addr  in  RF_AW each  source register addresses from decoder
- rs_used, rt_used  in  1 each  decoder says operand is read from the register file
- rf_rdata1, rf_rdata2  in  DW each  register-file read data for rs/rt
- fwd_valid  in  NUM_FWD  source i holds a valid register-writing instruction
- fwd_dest  in  NUM_FWD*RF_AW  destination of source i, slice [i*RF_AW +: RF_AW]
- fwd_data_ok  in  NUM_FWD  source i result is final (0 for load in EX, multi-cycle op)
- fwd_data  in  NUM_FWD*DW  result of source i, slice [i*DW +: DW]
- rs_value, rt_value  out  DW each  resolved operands
- src_stall  out  1  operand-not-ready stall, qualified by ds_valid
- stall_cnt  out  32  saturating count of src_stall cycles

## Operation
- Match rule per operand X ∈ {rs, rt}: hit[i] = fwd_valid[i] & X_used & (X_addr != 0) & (fwd_dest[i] == X_addr).
- Winner is the lowest i with hit[i]=1. X_value = fwd_data[winner]. With no hit, X_value = rf_rdataN. Lower-priority hits are ignored even if they are ready.
- X_wait = a winner exists & ~fwd_data_ok[winner]. src_stall = ds_valid & (rs_wait | rt_wait).
- ds_ready_go = ~src_stall. ds_to_es_valid = ds_valid & ds_ready_go & ~flush.
- ds_allowin = ~ds_valid | (ds_ready_go & es_allowin) | flush.
- ds_valid update, evaluated in priority order:
  - reset → 0.
  - else if flush → fs_to_ds_valid & ds_allowin. A new fetch in the same cycle is accepted; the held instruction is discarded.
  - else if ds_allowin → fs_to_ds_valid.
- ds_payload loads fs_to_ds_bus when fs_to_ds_valid & ds_allowin. Otherwise it holds.
- stall_cnt increments when src_stall=1 and ~flush, and saturates at 0xFFFF_FFFF.
- Values are pure combinational muxes. Operands are not registered, so a stalled instruction re-resolves every cycle until the producer's fwd_data_ok rises.

## Timing
- Reset values: ds_valid=0, ds_payload=0, stall_cnt=0. Therefore ds_to_es_valid=0, src_stall=0, ds_allowin=1.
- Latency: payload visible at ds_payload one cycle after acceptance. It issues to EX in that same cycle if not stalled.
- Bypass path: zero-cycle, combinational from fwd_* to rs_value/rt_value and src_stall.
- Stall boundary: fwd_data_ok rising in cycle N gives ds_to_es_valid=1 in cycle N (given es_allowin).
- Flush wins over stall. A stalled instruction under flush is dropped and is not counted that cycle.
- Reset mid-stall clears the slot and the counter on the next edge. No payload survives.
- es_allowin=0 with no stall holds the slot. ds_allowin=0 and the payload is stable.

## Structure
- Shared package/header: the FS_TO_DS bus width (PAYLOAD_W default) and the forwarding-bus slice macros (FWD_DEST(i), FWD_DATA(i)).
- One sub-module: ds_fwd_sel, a priority-select of one operand across NUM_FWD sources (outputs value and wait). It is instantiated twice, for rs and rt.

## Test plan
- Back-to-back adds, no conflicts: payloads issue one per cycle. rs_value = rf_rdata1. stall_cnt stays 0.
- Source 0 dest=5, data_ok=1, data=0x1111; source 2 dest=5, data=0x3333; rs_addr=5 → rs_value=0x1111, no stall.
- Load-use: source 0 dest=8, data_ok=0 for 1 cycle, then 1 with 0xCAFE; rt_addr=8 → src_stall=1 for 1 cycle, ds_allowin=0, then issues with rt_value=0xCAFE. stall_cnt=1.
- rs_addr=0 with source 0 dest=0, data_ok=0 → no stall, rs_value=rf_rdata1. rt_used=0 with a matching dest → no stall.
- Flush while stalled, with fs_to_ds_valid=1 → ds_to_es_valid=0 that cycle. Next cycle ds_valid=1 with the new payload. stall_cnt unchanged.
- Force stall_cnt near saturation (long stall, or preload via a bench hierarchical force to 0xFFFF_FFFE) → it reaches 0xFFFF_FFFF and holds. Reset mid-stall → all outputs return to reset values.

Source files
------------

// File: rtl/ds_bypass_stage_pkg.sv
// Shared definitions for the decode-stage bypass slot: fetch bus width,
// stall-counter ceiling and the forwarding-bus slice helper.
package ds_bypass_stage_pkg;

    localparam int          FS_TO_DS_BUS_W = 64;
    localparam logic [31:0] STALL_CNT_MAX  = 32'hFFFF_FFFF;

    // LSB of slice idx in a flattened per-source bus (FWD_DEST(i) / FWD_DATA(i)).
    function automatic int fwd_lsb(input int idx, input int slice_w);
        return idx * slice_w;
    endfunction

endpackage

// File: rtl/ds_fwd_sel.sv
// Priority select of one source operand across the forwarding ports;
// the nearest (lowest-index) matching producer wins, ready or not.
module ds_fwd_sel
    import ds_bypass_stage_pkg::*;
#(
    parameter int DW      = 32,
    parameter int RF_AW   = 5,
    parameter int NUM_FWD = 3
) (
    input  logic                     used_i,
    input  logic [RF_AW-1:0]         addr_i,
    input  logic [DW-1:0]            rf_rdata_i,
    input  logic [NUM_FWD-1:0]       fwd_valid_i,
    input  logic [NUM_FWD*RF_AW-1:0] fwd_dest_i,
    input  logic [NUM_FWD-1:0]       fwd_data_ok_i,
    input  logic [NUM_FWD*DW-1:0]    fwd_data_i,
    output logic [DW-1:0]            value_o,
    output logic                     wait_o
);

    logic found;
    logic hit;

    // Scan from nearest stage outward; the first hit locks the result.
    always_comb begin
        value_o = rf_rdata_i;
        wait_o  = 1'b0;
        found   = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            hit = fwd_valid_i[i] && used_i && (addr_i != {RF_AW{1'b0}}) &&
                  (fwd_dest_i[fwd_lsb(i, RF_AW) +: RF_AW] == addr_i);
            if (hit && !found) begin
                value_o = fwd_data_i[fwd_lsb(i, DW) +: DW];
                wait_o  = ~fwd_data_ok_i[i];
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    end

endmodule

// File: rtl/ds_bypass_stage.sv
// Decode-stage pipeline slot: holds the fetch payload, resolves rs/rt through
// the bypass network, stalls on not-ready producers and counts stall cycles.
module ds_bypass_stage
    import ds_bypass_stage_pkg::*;
#(
    parameter int DW        = 32,
    parameter int RF_AW     = 5,
    parameter int NUM_FWD   = 3,
    parameter int PAYLOAD_W = FS_TO_DS_BUS_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fs_to_ds_valid,
    input  logic [PAYLOAD_W-1:0]     fs_to_ds_bus,
    output logic                     ds_allowin,
    input  logic                     es_allowin,
    output logic                     ds_to_es_valid,
    input  logic                     flush,
    output logic                     ds_valid,
    output logic [PAYLOAD_W-1:0]     ds_payload,
    input  logic [RF_AW-1:0]         rs_addr,
    input  logic [RF_AW-1:0]         rt_addr,
    input  logic                     rs_used,
    input  logic                     rt_used,
    input  logic [DW-1:0]            rf_rdata1,
    input  logic [DW-1:0]            rf_rdata2,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [NUM_FWD*RF_AW-1:0] fwd_dest,
    input  logic [NUM_FWD-1:0]       fwd_data_ok,
    input  logic [NUM_FWD*DW-1:0]    fwd_data,
    output logic [DW-1:0]            rs_value,
    output logic [DW-1:0]            rt_value,
    output logic                     src_stall,
    output logic [31:0]              stall_cnt
);

    logic                 ds_valid_q,   ds_valid_d;
    logic [PAYLOAD_W-1:0] ds_payload_q, ds_payload_d;
    logic [31:0]          stall_cnt_q,  stall_cnt_d;
    logic                 rs_wait, rt_wait;
    logic                 ds_ready_go;

    ds_fwd_sel #(.DW(DW), .RF_AW(RF_AW), .NUM_FWD(NUM_FWD)) u_rs_sel (
        .used_i        (rs_used),
        .addr_i        (rs_addr),
        .rf_rdata_i    (rf_rdata1),
        .fwd_valid_i   (fwd_valid),
        .fwd_dest_i    (fwd_dest),
        .fwd_data_ok_i (fwd_data_ok),
        .fwd_data_i    (fwd_data),
        .value_o       (rs_value),
        .wait_o        (rs_wait)
    );

    ds_fwd_sel #(.DW(DW), .RF_AW(RF_AW), .NUM_FWD(NUM_FWD)) u_rt_sel (
        .used_i        (rt_used),
        .addr_i        (rt_addr),
        .rf_rdata_i    (rf_rdata2),
        .fwd_valid_i   (fwd_valid),
        .fwd_dest_i    (fwd_dest),
        .fwd_data_ok_i (fwd_data_ok),
        .fwd_data_i    (fwd_data),
        .value_o       (rt_value),
        .wait_o        (rt_wait)
    );

    // Flush frees the slot even while stalled, so the handshake sees it here.
    assign src_stall      = ds_valid_q & (rs_wait | rt_wait);
    assign ds_ready_go    = ~src_stall;
    assign ds_to_es_valid = ds_valid_q & ds_ready_go & ~flush;
    assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin) | flush;

    assign ds_valid   = ds_valid_q;
    assign ds_payload = ds_payload_q;
    assign stall_cnt  = stall_cnt_q;

    // Next-state for occupancy, payload and the saturating stall counter.
    always_comb begin
        ds_valid_d   = ds_valid_q;
        ds_payload_d = ds_payload_q;
        stall_cnt_d  = stall_cnt_q;
        if (flush) begin
            ds_valid_d = fs_to_ds_valid & ds_allowin;
        end else if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid;
        end else begin
            ds_valid_d = ds_valid_q;
        end
        if (fs_to_ds_valid && ds_allowin) begin
            ds_payload_d = fs_to_ds_bus;
        end else begin
            ds_payload_d = ds_payload_q;
        end
        if (src_stall && !flush && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Slot state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q   <= 1'b0;
            ds_payload_q <= {PAYLOAD_W{1'b0}};
            stall_cnt_q  <= 32'd0;
        end else begin
            ds_valid_q   <= ds_valid_d;
            ds_payload_q <= ds_payload_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_ds_bypass_stage.sv
// Directed self-checking bench for ds_bypass_stage: handshake, bypass priority,
// load-use stall, flush, counter saturation and reset.
module tb_ds_bypass_stage;

    localparam int DW = 32, RF_AW = 5, NUM_FWD = 3, PAYLOAD_W = 64;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     fs_to_ds_valid;
    logic [PAYLOAD_W-1:0]     fs_to_ds_bus;
    logic                     ds_allowin;
    logic                     es_allowin;
    logic                     ds_to_es_valid;
    logic                     flush;
    logic                     ds_valid;
    logic [PAYLOAD_W-1:0]     ds_payload;
    logic [RF_AW-1:0]         rs_addr, rt_addr;
    logic                     rs_used, rt_used;
    logic [DW-1:0]            rf_rdata1, rf_rdata2;
    logic [NUM_FWD-1:0]       fwd_valid;
    logic [NUM_FWD*RF_AW-1:0] fwd_dest;
    logic [NUM_FWD-1:0]       fwd_data_ok;
    logic [NUM_FWD*DW-1:0]    fwd_data;
    logic [DW-1:0]            rs_value, rt_value;
    logic                     src_stall;
    logic [31:0]              stall_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [PAYLOAD_W-1:0] exp_payload;

    ds_bypass_stage #(.DW(DW), .RF_AW(RF_AW), .NUM_FWD(NUM_FWD), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
        .flush(flush), .ds_valid(ds_valid), .ds_payload(ds_payload),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
        .fwd_data_ok(fwd_data_ok), .fwd_data(fwd_data), .rs_value(rs_value), .rt_value(rt_value),
        .src_stall(src_stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        fwd_valid   = 3'b000;
        fwd_dest    = 15'd0;
        fwd_data_ok = 3'b000;
        fwd_data    = 96'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        #1;
        total_cnt++; if (ds_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", ds_valid); else pass_cnt++;
        total_cnt++; if (ds_payload !== 64'd0) $display("FAIL rst_payload got %h exp 0", ds_payload); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL rst_cnt got %h exp 0", stall_cnt); else pass_cnt++;
        total_cnt++; if (ds_to_es_valid !== 1'b0) $display("FAIL rst_to_es got %b exp 0", ds_to_es_valid); else pass_cnt++;
        total_cnt++; if (src_stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", src_stall); else pass_cnt++;
        total_cnt++; if (ds_allowin !== 1'b1) $display("FAIL rst_allowin got %b exp 1", ds_allowin); else pass_cnt++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = 64'h0000_0013_0000_1000;
        exp_payload    = fs_to_ds_bus;
        rs_addr = 5'd3; rt_addr = 5'd4;
        step();
        for (int k = 1; k <= 4; k++) begin
            rf_rdata1 = 32'h0000_0100 + 32'(k);
            #1;
            total_cnt++; if (ds_payload !== exp_payload) $display("FAIL b2b_payload[%0d] got %h exp %h", k, ds_payload, exp_payload); else pass_cnt++;
            total_cnt++; if (ds_to_es_valid !== 1'b1) $display("FAIL b2b_issue[%0d] got %b exp 1", k, ds_to_es_valid); else pass_cnt++;
            total_cnt++; if (rs_value !== 32'h0000_0100 + 32'(k)) $display("FAIL b2b_rs[%0d] got %h exp %h", k, rs_value, 32'h0000_0100 + 32'(k)); else pass_cnt++;
            if (k == 4) begin
                fs_to_ds_valid = 1'b0;
            end else begin
                fs_to_ds_bus = 64'h0000_0013_0000_1000 + {32'(k), 32'(4 * k)};
                exp_payload  = fs_to_ds_bus;
            end
            step();
        end
        total_cnt++; if (ds_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", ds_valid); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL b2b_cnt got %h exp 0", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_priority();
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = 64'hAAAA_0001_0000_2000;
        es_allowin     = 1'b0;
        step();
        fs_to_ds_valid = 1'b0;
        // src0 dest=5 ready 0x1111, src1 dest=7 ready 0x2222, src2 dest=5 NOT ready 0x3333
        fwd_valid   = 3'b111;
        fwd_dest    = {5'd5, 5'd7, 5'd5};
        fwd_data_ok = 3'b011;
        fwd_data    = {32'h0000_3333, 32'h0000_2222, 32'h0000_1111};
        rs_addr = 5'd5; rt_addr = 5'd7;
        #1;
        total_cnt++; if (rs_value !== 32'h0000_1111) $display("FAIL prio_rs got %h exp 00001111", rs_value); else pass_cnt++;
        total_cnt++; if (rt_value !== 32'h0000_2222) $display("FAIL prio_rt got %h exp 00002222", rt_value); else pass_cnt++;
        total_cnt++; if (src_stall !== 1'b0) $display("FAIL prio_nostall got %b exp 0", src_stall); else pass_cnt++;
        total_cnt++; if (ds_allowin !== 1'b0) $display("FAIL hold_allowin got %b exp 0", ds_allowin); else pass_cnt++;
        // Nearest producer not ready, farther one ready: must stall on the nearest.
        fwd_dest    = {5'd7, 5'd5, 5'd5};
        fwd_data_ok = 3'b110;
        #1;
        total_cnt++; if (src_stall !== 1'b1) $display("FAIL prio_near_wait got %b exp 1", src_stall); else pass_cnt++;
        total_cnt++; if (rs_value !== 32'h0000_1111) $display("FAIL prio_near_val got %h exp 00001111", rs_value); else pass_cnt++;
        clear_fwd();
        step();
        total_cnt++; if (ds_payload !== 64'hAAAA_0001_0000_2000) $display("FAIL hold_payload got %h exp aaaa000100002000", ds_payload); else pass_cnt++;
        total_cnt++; if (ds_valid !== 1'b1) $display("FAIL hold_valid got %b exp 1", ds_valid); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL prio_cnt got %h exp 0", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        fwd_valid = 3'b001; fwd_dest = {5'd0, 5'd0, 5'd0}; fwd_data_ok = 3'b000;
        fwd_data  = {32'd0, 32'd0, 32'hDEAD_0000};
        rs_addr = 5'd0; rf_rdata1 = 32'h0000_5A5A;
        rt_addr = 5'd31;
        #1;
        total_cnt++; if (src_stall !== 1'b0) $display("FAIL zero_stall got %b exp 0", src_stall); else pass_cnt++;
        total_cnt++; if (rs_value !== 32'h0000_5A5A) $display("FAIL zero_rs got %h exp 00005a5a", rs_value); else pass_cnt++;
        fwd_dest = {5'd0, 5'd0, 5'd9};
        rs_addr = 5'd1; rt_addr = 5'd9; rt_used = 1'b0; rf_rdata2 = 32'h0000_7777;
        #1;
        total_cnt++; if (src_stall !== 1'b0) $display("FAIL unused_stall got %b exp 0", src_stall); else pass_cnt++;
        total_cnt++; if (rt_value !== 32'h0000_7777) $display("FAIL unused_rt got %h exp 00007777", rt_value); else pass_cnt++;
        rt_used = 1'b1;
        clear_fwd();
        es_allowin = 1'b1;
        step();
        total_cnt++; if (ds_valid !== 1'b0) $display("FAIL zero_drain got %b exp 0", ds_valid); else pass_cnt++;
    endtask

    task automatic test_load_use();
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = 64'h0000_0A0A_0000_3000;
        step();
        fs_to_ds_bus = 64'h0000_0B0B_0000_3004;
        fwd_valid = 3'b001; fwd_dest = {5'd0, 5'd0, 5'd8}; fwd_data_ok = 3'b000;
        fwd_data  = {32'd0, 32'd0, 32'h0000_0BAD};
        rs_addr = 5'd2; rt_addr = 5'd8;
        #1;
        total_cnt++; if (src_stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", src_stall); else pass_cnt++;
        total_cnt++; if (ds_allowin !== 1'b0) $display("FAIL lu_allowin got %b exp 0", ds_allowin); else pass_cnt++;
        total_cnt++; if (ds_to_es_valid !== 1'b0) $display("FAIL lu_noissue got %b exp 0", ds_to_es_valid); else pass_cnt++;
        step();
        total_cnt++; if (ds_payload !== 64'h0000_0A0A_0000_3000) $display("FAIL lu_held got %h exp 00000a0a00003000", ds_payload); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd1) $display("FAIL lu_cnt got %h exp 1", stall_cnt); else pass_cnt++;
        fwd_data_ok = 3'b001;
        fwd_data    = {32'd0, 32'd0, 32'h0000_CAFE};
        #1;
        total_cnt++; if (ds_to_es_valid !== 1'b1) $display("FAIL lu_issue got %b exp 1", ds_to_es_valid); else pass_cnt++;
        total_cnt++; if (rt_value !== 32'h0000_CAFE) $display("FAIL lu_rt got %h exp 0000cafe", rt_value); else pass_cnt++;
        total_cnt++; if (src_stall !== 1'b0) $display("FAIL lu_release got %b exp 0", src_stall); else pass_cnt++;
        step();
        clear_fwd();
        fs_to_ds_valid = 1'b0;
        total_cnt++; if (ds_payload !== 64'h0000_0B0B_0000_3004) $display("FAIL lu_next got %h exp 00000b0b00003004", ds_payload); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd1) $display("FAIL lu_cnt2 got %h exp 1", stall_cnt); else pass_cnt++;
        step();
    endtask

    task automatic test_flush_stall();
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = 64'h0000_0C0C_0000_4000;
        step();
        fwd_valid = 3'b001; fwd_dest = {5'd0, 5'd0, 5'd8}; fwd_data_ok = 3'b000;
        rt_addr = 5'd8;
        flush = 1'b1;
        fs_to_ds_bus = 64'h0000_0D0D_0000_8000;
        #1;
        total_cnt++; if (ds_to_es_valid !== 1'b0) $display("FAIL fl_issue got %b exp 0", ds_to_es_valid); else pass_cnt++;
        total_cnt++; if (ds_allowin !== 1'b1) $display("FAIL fl_allowin got %b exp 1", ds_allowin); else pass_cnt++;
        step();
        flush = 1'b0;
        fs_to_ds_valid = 1'b0;
        clear_fwd();
        #1;
        total_cnt++; if (ds_valid !== 1'b1) $display("FAIL fl_valid got %b exp 1", ds_valid); else pass_cnt++;
        total_cnt++; if (ds_payload !== 64'h0000_0D0D_0000_8000) $display("FAIL fl_payload got %h exp 00000d0d00008000", ds_payload); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd1) $display("FAIL fl_cnt got %h exp 1", stall_cnt); else pass_cnt++;
        step();
    endtask

    task automatic test_saturation_reset();
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = 64'h0000_0E0E_0000_9000;
        step();
        fs_to_ds_valid = 1'b0;
        fwd_valid = 3'b010; fwd_dest = {5'd0, 5'd12, 5'd0}; fwd_data_ok = 3'b000;
        rs_addr = 5'd12;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        total_cnt++; if (stall_cnt !== 32'hFFFF_FFFE) $display("FAIL sat_preload got %h exp fffffffe", stall_cnt); else pass_cnt++;
        step();
        total_cnt++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_max got %h exp ffffffff", stall_cnt); else pass_cnt++;
        step();
        total_cnt++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_hold got %h exp ffffffff", stall_cnt); else pass_cnt++;
        total_cnt++; if (src_stall !== 1'b1) $display("FAIL sat_stall got %b exp 1", src_stall); else pass_cnt++;
        reset = 1'b1;
        step();
        total_cnt++; if (ds_valid !== 1'b0) $display("FAIL mrst_valid got %b exp 0", ds_valid); else pass_cnt++;
        total_cnt++; if (ds_payload !== 64'd0) $display("FAIL mrst_payload got %h exp 0", ds_payload); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL mrst_cnt got %h exp 0", stall_cnt); else pass_cnt++;
        total_cnt++; if (src_stall !== 1'b0) $display("FAIL mrst_stall got %b exp 0", src_stall); else pass_cnt++;
        total_cnt++; if (ds_allowin !== 1'b1) $display("FAIL mrst_allowin got %b exp 1", ds_allowin); else pass_cnt++;
        total_cnt++; if (ds_to_es_valid !== 1'b0) $display("FAIL mrst_to_es got %b exp 0", ds_to_es_valid); else pass_cnt++;
        reset = 1'b0;
        clear_fwd();
    endtask

    initial begin
        reset = 1'b1; fs_to_ds_valid = 1'b0; fs_to_ds_bus = 64'd0;
        es_allowin = 1'b1; flush = 1'b0;
        rs_addr = 5'd0; rt_addr = 5'd0; rs_used = 1'b1; rt_used = 1'b1;
        rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
        exp_payload = 64'd0;
        clear_fwd();
        test_reset();
        test_back_to_back();
        test_priority();
        test_zero_reg();
        test_load_use();
        test_flush_stall();
        test_saturation_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
